// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial R = A - B - Bor_in, LSB first, one bit per clock.
// A start/busy/done handshake fronts the datapath. R and Bor_out only move on
// the edge that finishes the last bit, so consumers never see partial sums.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bor_in,
   output logic [WIDTH-1:0] R,
   output logic             Bor_out,
   output logic             busy,
   output logic             done
);

   // Counter wide enough to index every bit of the operands.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_bor_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_bor;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_r;
   logic             r_bor_out;
   logic             r_busy;
   logic             r_done;

   // One full-subtractor cell working on the current LSBs of the shift registers.
   assign w_d        = r_a[0] ^ r_b[0] ^ r_bor;
   assign w_bor_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. start is only honoured when busy is low (IDLE or DONE).
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = RUN;
               w_accept     = 1'b1;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               w_state_next = RUN;
               w_accept     = 1'b1;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, then shift one bit per RUN cycle and
   // publish the completed result together with the final borrow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_bor     <= 1'b0;
         r_res     <= '0;
         r_cnt     <= '0;
         r_r       <= '0;
         r_bor_out <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_bor <= Bor_in;
            r_res <= '0;
            r_cnt <= '0;
         end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_bor <= w_bor_next;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_r       <= {w_d, r_res[WIDTH-1:1]};
               r_bor_out <= w_bor_next;
            end
         end
         r_busy <= (w_state_next == RUN);
         r_done <= (r_state == RUN) && w_last;
      end
   end

   assign R       = r_r;
   assign Bor_out = r_bor_out;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vector table plus hand-written sequences for
// start-while-busy, back-to-back operation and mid-operation reset.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       Bor_in = 1'b0;
   logic [7:0] R;
   logic       Bor_out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] exp_r;
      logic       exp_bor;
   } vec_t;

   vec_t vecs [9];

   serial_subtractor #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .Bor_in  (Bor_in),
      .R       (R),
      .Bor_out (Bor_out),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Runs one operation from idle, checking the busy window, latency and result.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [7:0] exp_r, input logic exp_bor);
      logic [7:0] prev_r;
      logic       prev_bor;
      bit         window_ok;
      prev_r   = R;
      prev_bor = Bor_out;
      A = a; B = b; Bor_in = bin; start = 1'b1;
      tick();
      start = 1'b0; A = ~a; B = ~b; Bor_in = ~bin;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      window_ok = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         if (busy !== 1'b1 || done !== 1'b0 || R !== prev_r || Bor_out !== prev_bor)
            window_ok = 1'b0;
      end
      check("run_window_held", {31'd0, window_ok}, 32'd1);
      tick();
      check("done_at_k8", {31'd0, done}, 32'd1);
      check("busy_low_at_k8", {31'd0, busy}, 32'd0);
      check("result_r", {24'd0, R}, {24'd0, exp_r});
      check("result_bor", {31'd0, Bor_out}, {31'd0, exp_bor});
      $display("op A=%0d B=%0d Bin=%0d -> R=%0d Bor=%0d (want %0d/%0d)",
               a, b, bin, R, Bor_out, exp_r, exp_bor);
      tick();
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      int         done_cyc [2];
      logic [7:0] cap_r [2];
      logic       cap_bor [2];
      int         nd;
      bit         saw_done;
      logic [7:0] prev_r;
      logic [7:0] ra, rb;
      logic       rbin;
      logic [8:0] ref9;

      vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
      vecs[1] = '{8'd37,  8'd100, 1'b0, 8'd193, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
      vecs[4] = '{8'd10,  8'd3,   1'b0, 8'd7,   1'b0};
      vecs[5] = '{8'd3,   8'd10,  1'b0, 8'd249, 1'b1};
      vecs[6] = '{8'd128, 8'd1,   1'b1, 8'd126, 1'b0};
      vecs[7] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1};
      vecs[8] = '{8'd77,  8'd77,  1'b0, 8'd0,   1'b0};

      // Reset state, with start asserted to show reset wins.
      rst = 1'b1; start = 1'b1; A = 8'd5; B = 8'd1;
      tick(); tick();
      check("reset_R", {24'd0, R}, 32'd0);
      check("reset_Bor", {31'd0, Bor_out}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      start = 1'b0; rst = 1'b0;
      tick();

      // Vector table.
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_r, vecs[i].exp_bor);
      end

      // start while busy is ignored; R holds until the final edge.
      prev_r = R;
      A = 8'd200; B = 8'd50; Bor_in = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; A = 8'd1; B = 8'd2;
      tick();
      start = 1'b0;
      check("ignore_busy", {31'd0, busy}, 32'd1);
      check("ignore_R_held", {24'd0, R}, {24'd0, prev_r});
      for (int i = 4; i < 8; i++) tick();
      check("ignore_R_held_k7", {24'd0, R}, {24'd0, prev_r});
      tick();
      check("ignore_done", {31'd0, done}, 32'd1);
      check("ignore_R", {24'd0, R}, 32'd150);
      check("ignore_Bor", {31'd0, Bor_out}, 32'd0);
      $display("op A=200 B=50 (ignored start 1-2) -> R=%0d Bor=%0d", R, Bor_out);
      tick();
      tick();
      check("ignore_idle", {30'd0, busy, done}, 32'd0);

      // Back-to-back with start held through DONE.
      nd = 0;
      A = 8'd10; B = 8'd3; Bor_in = 1'b0; start = 1'b1;
      tick();
      A = 8'd3; B = 8'd10;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 9) start = 1'b0;
         if (done === 1'b1) begin
            if (nd < 2) begin
               done_cyc[nd] = c;
               cap_r[nd]    = R;
               cap_bor[nd]  = Bor_out;
            end
            nd++;
         end
      end
      check("b2b_count", nd, 32'd2);
      if (nd >= 2) begin
         check("b2b_first_cycle", done_cyc[0], 32'd8);
         check("b2b_spacing", done_cyc[1] - done_cyc[0], 32'd9);
         check("b2b_R0", {24'd0, cap_r[0]}, 32'd7);
         check("b2b_Bor0", {31'd0, cap_bor[0]}, 32'd0);
         check("b2b_R1", {24'd0, cap_r[1]}, 32'd249);
         check("b2b_Bor1", {31'd0, cap_bor[1]}, 32'd1);
         $display("op back-to-back -> R=%0d/%0d Bor=%0d/%0d", cap_r[0], cap_r[1], cap_bor[0], cap_bor[1]);
      end

      // Reset mid-operation aborts without a done pulse.
      A = 8'd50; B = 8'd20; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_R", {24'd0, R}, 32'd0);
      check("abort_Bor", {31'd0, Bor_out}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done !== 1'b0) saw_done = 1'b1;
         tick();
      end
      check("abort_no_done", {31'd0, saw_done}, 32'd0);
      $display("op A=50 B=20 aborted by reset -> R=%0d busy=%0d", R, busy);
      run_op(8'd9, 8'd4, 1'b0, 8'd5, 1'b0);

      // Random vectors against the 9-bit reference A - B - Bor_in.
      for (int n = 0; n < 20; n++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
         run_op(ra, rb, rbin, ref9[7:0], ref9[8]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
